// File: rtl/lut_layer_pkg.sv
// Shared types and sizing helpers for the LogicNets truth-table layer.
// Readback port enabled with LUT_LAYER_READBACK_EN (see lut_layer_pipe).
package lut_layer_pkg;

  localparam int unsigned MaxSelW       = 8;
  localparam int unsigned MaxAddrW      = 16;
  localparam int unsigned MaxDataW      = 16;
  localparam int unsigned DefaultInBits = 4;

  // Neuron select needs at least one bit even for a single-neuron layer.
  function automatic int unsigned neuron_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned tbl_depth(input int unsigned in_bits);
    return 32'd1 << in_bits;
  endfunction

  localparam int unsigned DEPTH = tbl_depth(DefaultInBits);

  typedef struct packed {
    logic [MaxSelW-1:0]  neuron;
    logic [MaxAddrW-1:0] addr;
    logic [MaxDataW-1:0] data;
  } cfg_beat_t;

endpackage

// File: rtl/lut_neuron_tbl.sv
// One neuron's register truth table: one write port, one combinational lookup,
// and a combinational readback port when LUT_LAYER_READBACK_EN is defined.
module lut_neuron_tbl
  import lut_layer_pkg::*;
#(
  parameter int unsigned InBits  = 4,
  parameter int unsigned OutBits = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [InBits-1:0]  waddr_i,
  input  logic [OutBits-1:0] wdata_i,
  input  logic [InBits-1:0]  lkup_addr_i,
  output logic [OutBits-1:0] lkup_data_o
`ifdef LUT_LAYER_READBACK_EN
  ,
  input  logic [InBits-1:0]  rd_addr_i,
  output logic [OutBits-1:0] rd_data_o
`endif
);

  localparam int unsigned Depth = tbl_depth(InBits);

  logic [OutBits-1:0] mem_q [Depth];

  // Tables are cleared on every reset and must be reloaded afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign lkup_data_o = mem_q[lkup_addr_i];

`ifdef LUT_LAYER_READBACK_EN
  assign rd_data_o = mem_q[rd_addr_i];
`endif

endmodule

// File: rtl/lut_layer_pipe.sv
// Pipelined LogicNets layer of runtime-loadable truth-table neurons, one output register stage.
// Define LUT_LAYER_READBACK_EN to add the cfg_re/cfg_rvalid/cfg_rdata table readback port.
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned IN_BITS   = 4,
  parameter int unsigned OUT_BITS  = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [N_NEURONS*IN_BITS-1:0]      in_data_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [N_NEURONS*OUT_BITS-1:0]     out_data_o,
  input  logic                              cfg_we_i,
  input  logic [neuron_sel_w(N_NEURONS)-1:0] cfg_neuron_i,
  input  logic [IN_BITS-1:0]                cfg_addr_i,
  input  logic [OUT_BITS-1:0]               cfg_data_i,
  output logic                              cfg_err_o,
  output logic [CNT_W-1:0]                  sample_cnt_o
`ifdef LUT_LAYER_READBACK_EN
  ,
  input  logic                              cfg_re_i,
  output logic                              cfg_rvalid_o,
  output logic [OUT_BITS-1:0]               cfg_rdata_o
`endif
);

  localparam int unsigned OutW = N_NEURONS * OUT_BITS;

  cfg_beat_t           beat;
  logic [31:0]         sel_ext;
  logic                sel_ok;
  logic                accept;
  logic [OutW-1:0]     lkup_data;

  logic                out_valid_q, out_valid_d;
  logic [OutW-1:0]     out_data_q, out_data_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    beat        = '0;
    beat.neuron = MaxSelW'(cfg_neuron_i);
    beat.addr   = MaxAddrW'(cfg_addr_i);
    beat.data   = MaxDataW'(cfg_data_i);
  end

  assign sel_ext = 32'(beat.neuron);
  assign sel_ok  = (sel_ext < N_NEURONS);

`ifdef LUT_LAYER_READBACK_EN
  logic [OUT_BITS-1:0] rd_data [N_NEURONS];
  logic                rvalid_q, rvalid_d;
  logic [OUT_BITS-1:0] rdata_q, rdata_d;
`endif

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic we_k;
    assign we_k = cfg_we_i && sel_ok && (sel_ext == k);

    lut_neuron_tbl #(
      .InBits (IN_BITS),
      .OutBits(OUT_BITS)
    ) u_tbl (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .we_i       (we_k),
      .waddr_i    (beat.addr[IN_BITS-1:0]),
      .wdata_i    (beat.data[OUT_BITS-1:0]),
      .lkup_addr_i(in_data_i[k*IN_BITS +: IN_BITS]),
      .lkup_data_o(lkup_data[k*OUT_BITS +: OUT_BITS])
`ifdef LUT_LAYER_READBACK_EN
      ,
      .rd_addr_i  (beat.addr[IN_BITS-1:0]),
      .rd_data_o  (rd_data[k])
`endif
    );
  end

  // A write cycle blocks lookups so a lookup never races a table update.
  assign in_ready_o = !cfg_we_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lkup_data;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    cfg_err_d = cfg_we_i && !sel_ok;
`ifdef LUT_LAYER_READBACK_EN
    cfg_err_d = cfg_err_d || (cfg_re_i && !sel_ok);
`endif
  end

`ifdef LUT_LAYER_READBACK_EN
  // Out-of-range reads still answer, with zero data.
  always_comb begin
    rvalid_d = cfg_re_i;
    rdata_d  = '0;
    if (cfg_re_i && sel_ok) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        if (sel_ext == k) begin
          rdata_d = rd_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign cfg_err_o    = cfg_err_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Directed bench for lut_layer_pipe: a default 4-neuron layer plus a 3-neuron,
// 4-bit-counter layer for out-of-range config writes and counter wrap.
module tb_lut_layer_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data;
  logic [7:0]  out_data;
  logic        cfg_we, cfg_err;
  logic [1:0]  cfg_neuron;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic [15:0] sample_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_in_data;
  logic [5:0]  b_out_data;
  logic        b_cfg_we, b_cfg_err;
  logic [1:0]  b_cfg_neuron;
  logic [3:0]  b_cfg_addr;
  logic [1:0]  b_cfg_data;
  logic [3:0]  b_sample_cnt;

`ifdef LUT_LAYER_READBACK_EN
  logic       cfg_re, cfg_rvalid, b_cfg_re, b_cfg_rvalid;
  logic [1:0] cfg_rdata, b_cfg_rdata;
`endif

  lut_layer_pipe dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .cfg_we_i    (cfg_we),
    .cfg_neuron_i(cfg_neuron),
    .cfg_addr_i  (cfg_addr),
    .cfg_data_i  (cfg_data),
    .cfg_err_o   (cfg_err),
    .sample_cnt_o(sample_cnt)
`ifdef LUT_LAYER_READBACK_EN
    ,
    .cfg_re_i    (cfg_re),
    .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o (cfg_rdata)
`endif
  );

  lut_layer_pipe #(
    .N_NEURONS(3),
    .IN_BITS  (4),
    .OUT_BITS (2),
    .CNT_W    (4)
  ) dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (b_in_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in_data),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_data_o  (b_out_data),
    .cfg_we_i    (b_cfg_we),
    .cfg_neuron_i(b_cfg_neuron),
    .cfg_addr_i  (b_cfg_addr),
    .cfg_data_i  (b_cfg_data),
    .cfg_err_o   (b_cfg_err),
    .sample_cnt_o(b_sample_cnt)
`ifdef LUT_LAYER_READBACK_EN
    ,
    .cfg_re_i    (b_cfg_re),
    .cfg_rvalid_o(b_cfg_rvalid),
    .cfg_rdata_o (b_cfg_rdata)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] i4;
    logic [7:0] exp6;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    b_cfg_we = 1'b0; b_cfg_neuron = '0; b_cfg_addr = '0; b_cfg_data = '0;
`ifdef LUT_LAYER_READBACK_EN
    cfg_re = 1'b0; b_cfg_re = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // 1: reset state and a first lookup
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_b_out_valid", b_out_valid, 0);
`ifdef LUT_LAYER_READBACK_EN
    chk("rst_rvalid", cfg_rvalid, 0);
    chk("rst_rdata", cfg_rdata, 0);
`endif
    in_valid = 1'b1; in_data = 16'h0000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 8'h00);
    chk("first_cnt", sample_cnt, 1);
    tick();
    chk("first_consumed", out_valid, 0);

    // 2: load tables and stream 16 samples
    cfg_we = 1'b1;
    for (int a = 0; a < 16; a++) begin
      cfg_neuron = 2'd0; cfg_addr = a[3:0]; cfg_data = {a[2], a[2]};
      tick();
    end
    for (int n = 1; n < 4; n++) begin
      for (int a = 0; a < 16; a++) begin
        cfg_neuron = n[1:0]; cfg_addr = a[3:0]; cfg_data = 2'b01;
        tick();
      end
    end
    cfg_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i4 = i[3:0];
      in_valid = 1'b1; in_data = {4'hf, 4'h3, 4'ha, i4};
      #1;
      chk("stream_in_ready", in_ready, 1);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i4[2] ? 8'h57 : 8'h54);
    end
    in_valid = 1'b0;
    chk("stream_cnt", sample_cnt, 17);

    // 3: backpressure holds the output stage
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0000;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("hold_in_ready", in_ready, 0);
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'h57);
    end
    chk("hold_cnt", sample_cnt, 17);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_valid", out_valid, 0);
    chk("release_data_held", out_data, 8'h57);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("after_hold_valid", out_valid, 1);
    chk("after_hold_data", out_data, 8'h54);
    chk("after_hold_cnt", sample_cnt, 18);
    tick();
    chk("after_hold_drain", out_valid, 0);

    // 4: write blocks accept; new entry visible next cycle
    cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 4'd5; cfg_data = 2'b10;
    in_valid = 1'b1; in_data = 16'h0005;
    #1;
    chk("we_in_ready", in_ready, 0);
    tick();
    chk("we_no_accept", out_valid, 0);
    chk("we_no_cnt", sample_cnt, 18);
    cfg_we = 1'b0;
    #1;
    chk("post_we_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("post_we_valid", out_valid, 1);
    chk("post_we_data", out_data, 8'h56);
    chk("post_we_cnt", sample_cnt, 19);
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_data = 2'b01;
    tick();
    cfg_we = 1'b0;
    chk("reg_out_kept", out_data, 8'h56);
    out_ready = 1'b1;
    tick();
    chk("reg_out_drain", out_valid, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rewrite_data", out_data, 8'h55);
    tick();

`ifdef LUT_LAYER_READBACK_EN
    cfg_re = 1'b1; cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 4'd5; cfg_data = 2'b11;
    tick();
    cfg_we = 1'b0;
    chk("rb_old_valid", cfg_rvalid, 1);
    chk("rb_old_data", cfg_rdata, 2'b01);
    #1;
    chk("rb_in_ready", in_ready, 1);
    tick();
    cfg_re = 1'b0;
    chk("rb_new_data", cfg_rdata, 2'b11);
    tick();
    chk("rb_idle", cfg_rvalid, 0);
    b_cfg_re = 1'b1; b_cfg_neuron = 2'd3; b_cfg_addr = 4'd0;
    tick();
    b_cfg_re = 1'b0;
    chk("rb_oor_valid", b_cfg_rvalid, 1);
    chk("rb_oor_data", b_cfg_rdata, 0);
    chk("rb_oor_err", b_cfg_err, 1);
    tick();
`endif

    // 5: out-of-range write on the 3-neuron layer
    b_cfg_we = 1'b1; b_cfg_neuron = 2'd3; b_cfg_addr = 4'd0; b_cfg_data = 2'b11;
    tick();
    b_cfg_we = 1'b0;
    chk("oor_err_pulse", b_cfg_err, 1);
    chk("main_no_err", cfg_err, 0);
    tick();
    chk("oor_err_drop", b_cfg_err, 0);
    b_cfg_we = 1'b1; b_cfg_neuron = 2'd2;
    tick();
    b_cfg_we = 1'b0;
    chk("valid_we_no_err", b_cfg_err, 0);
    b_in_valid = 1'b1; b_in_data = 12'h000;
    tick();
    b_in_valid = 1'b0;
    chk("oor_tables_intact", b_out_data, 6'h30);
    chk("b_cnt_one", b_sample_cnt, 1);

    // 6a: counter wrap on the 4-bit counter
    b_in_valid = 1'b1;
    for (int w = 0; w < 14; w++) tick();
    chk("cnt_full", b_sample_cnt, 15);
    tick();
    b_in_valid = 1'b0;
    chk("cnt_wrap", b_sample_cnt, 0);

    // 6b: reset with a pending output
    exp6 = 8'h55;
`ifdef LUT_LAYER_READBACK_EN
    exp6 = 8'h57;
`endif
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hfff5;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, exp6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", sample_cnt, 0);
    out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_tables_clear", out_data, 0);
    chk("post_rst_cnt", sample_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
